// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch and matrix-op stall/flush
// plus matrix unit sequencing with watchdog. Optional stats via HAZARD_STATS_EN.
//
// Ports:
//   clk, rst (sync, active-low)
//   id_rs1/id_rs2/id_rs1_used/id_rs2_used/id_mat_valid : ID stage info
//   ex_rd/ex_mem_read/ex_branch_taken                  : EX stage info
//   mat_done                                           : matrix completion pulse
//   pc_stall/if_id_stall/if_id_flush/id_ex_flush       : pipeline controls
//   mat_start/mat_busy/mat_err                         : matrix sequencing
//   stat_stall_cycles/stat_flushes/stat_mat_ops        : saturating counters
//
// Macro HAZARD_STATS_EN enables the stat_* counters; otherwise they read 0.
module pipe_hazard_ctrl #(
    parameter int MAT_TIMEOUT = 1024,
    parameter int CNT_W       = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic        id_mat_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mat_done,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mat_start,
    output logic        mat_busy,
    output logic        mat_err,
    output logic [31:0] stat_stall_cycles,
    output logic [31:0] stat_flushes,
    output logic [31:0] stat_mat_ops
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam bit             WD_EN   = (MAT_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MAT_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic lu;
    logic wd_hit;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c;
    logic id_ex_flush_c, mat_start_c, mat_busy_c;

    assign lu = ex_mem_read & (ex_rd != 5'd0) &
                ((id_rs1_used & (id_rs1 == ex_rd)) |
                 (id_rs2_used & (id_rs2 == ex_rd)));

    assign wd_hit = WD_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        pc_stall_c    = 1'b0;
        if_id_stall_c = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        mat_start_c   = 1'b0;
        mat_busy_c    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (lu) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (id_mat_valid) begin
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mat_start_c   = 1'b1;
                mat_busy_c    = 1'b1;
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                id_ex_flush_c = 1'b1;
                cnt_d         = '0;
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                mat_busy_c    = 1'b1;
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                id_ex_flush_c = 1'b1;
                cnt_d         = cnt_q + CNT_W'(1);
                // Completion takes precedence over a coincident timeout.
                if (mat_done) begin
                    state_d = S_DONE;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Every output is forced low while reset is held.
    assign pc_stall    = rst & pc_stall_c;
    assign if_id_stall = rst & if_id_stall_c;
    assign if_id_flush = rst & if_id_flush_c;
    assign id_ex_flush = rst & id_ex_flush_c;
    assign mat_start   = rst & mat_start_c;
    assign mat_busy    = rst & mat_busy_c;
    assign mat_err     = rst & err_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q, flush_q, ops_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
            ops_q   <= '0;
        end else begin
            if (pc_stall_c && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (if_id_flush_c && (flush_q != '1)) flush_q <= flush_q + 32'd1;
            if (mat_start_c && (ops_q != '1)) ops_q <= ops_q + 32'd1;
        end
    end

    assign stat_stall_cycles = rst ? stall_q : 32'd0;
    assign stat_flushes      = rst ? flush_q : 32'd0;
    assign stat_mat_ops      = rst ? ops_q   : 32'd0;
`else
    assign stat_stall_cycles = 32'd0;
    assign stat_flushes      = 32'd0;
    assign stat_mat_ops      = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table-driven IDLE hazard vectors plus
// directed matrix-op, watchdog and reset sequences.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, id_mat_valid;
    logic        ex_mem_read, ex_branch_taken, mat_done;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush;
    logic        mat_start, mat_busy, mat_err;
    logic [31:0] stat_stall_cycles, stat_flushes, stat_mat_ops;
    logic [5:0]  ctl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MAT_TIMEOUT(8), .CNT_W(11)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_rs1_used       (id_rs1_used),
        .id_rs2_used       (id_rs2_used),
        .id_mat_valid      (id_mat_valid),
        .ex_rd             (ex_rd),
        .ex_mem_read       (ex_mem_read),
        .ex_branch_taken   (ex_branch_taken),
        .mat_done          (mat_done),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .mat_start         (mat_start),
        .mat_busy          (mat_busy),
        .mat_err           (mat_err),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flushes      (stat_flushes),
        .stat_mat_ops      (stat_mat_ops)
    );

    // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, mat_start, mat_busy}
    assign ctl = {pc_stall, if_id_stall, if_id_flush,
                  id_ex_flush, mat_start, mat_busy};

    typedef struct {
        string      nm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mv;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b110100;
    localparam logic [5:0] C_FLUSH = 6'b001100;
    localparam logic [5:0] C_ISSUE = 6'b110111;
    localparam logic [5:0] C_WAIT  = 6'b110101;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_mat_valid = 1'b0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mat_done = 1'b0;
    endtask

    task automatic do_reset();
        tick(); rst = 1'b0; #1;
        chk("rst_ctl", {26'd0, ctl}, {26'd0, C_NONE});
        chk("rst_err", {31'd0, mat_err}, 32'd0);
        tick(); rst = 1'b1;
    endtask

    logic [31:0] exp_stall, exp_ops;

    initial begin
        vecs[0] = '{"none",      5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, C_NONE};
        vecs[1] = '{"lu_rs1",    5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, C_STALL};
        vecs[2] = '{"lu_x0",     5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0, C_NONE};
        vecs[3] = '{"rs1_unused",5'd5, 5'd0, 0, 0, 0, 5'd5, 1, 0, C_NONE};
        vecs[4] = '{"lu_rs2",    5'd1, 5'd9, 0, 1, 0, 5'd9, 1, 0, C_STALL};
        vecs[5] = '{"no_load",   5'd9, 5'd9, 1, 1, 0, 5'd9, 0, 0, C_NONE};
        vecs[6] = '{"br_over_lu",5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 1, C_FLUSH};
        vecs[7] = '{"br_over_mv",5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 1, C_FLUSH};
        vecs[8] = '{"br_only",   5'd3, 5'd4, 1, 1, 0, 5'd7, 0, 1, C_FLUSH};
        vecs[9] = '{"rd_miss",   5'd3, 5'd4, 1, 1, 0, 5'd7, 1, 0, C_NONE};

        idle_inputs();
        rst = 1'b0;
        // Hazard-provoking inputs during reset must not reach outputs.
        id_mat_valid = 1'b1; ex_branch_taken = 1'b1;
        repeat (2) tick();
        #1;
        chk("reset_ctl", {26'd0, ctl}, {26'd0, C_NONE});
        chk("reset_err", {31'd0, mat_err}, 32'd0);
        chk("reset_stat", stat_stall_cycles | stat_flushes | stat_mat_ops,
            32'd0);
        tick(); idle_inputs(); rst = 1'b1;

        // IDLE combinational vectors; none leaves IDLE.
        for (int i = 0; i < 10; i++) begin
            tick();
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_rs1_used = vecs[i].u1; id_rs2_used = vecs[i].u2;
            id_mat_valid = vecs[i].mv; ex_rd = vecs[i].rd;
            ex_mem_read = vecs[i].mr; ex_branch_taken = vecs[i].br;
            #1;
            chk(vecs[i].nm, {26'd0, ctl}, {26'd0, vecs[i].exp});
        end
        tick(); idle_inputs(); #1;
        chk("after_table_idle", {26'd0, ctl}, {26'd0, C_NONE});

        // Matrix op with done after four WAIT cycles.
        do_reset();
        tick(); id_mat_valid = 1'b1; #1;
        chk("mat_T", {26'd0, ctl}, {26'd0, C_STALL});
        tick(); #1;
        chk("mat_issue", {26'd0, ctl}, {26'd0, C_ISSUE});
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("mat_wait", {26'd0, ctl}, {26'd0, C_WAIT});
        end
        tick(); mat_done = 1'b1; #1;
        chk("mat_wait_done", {26'd0, ctl}, {26'd0, C_WAIT});
        tick(); mat_done = 1'b0; #1;
        chk("mat_done_state", {26'd0, ctl}, {26'd0, C_NONE});
        tick(); id_mat_valid = 1'b0; #1;
        chk("mat_back_idle", {26'd0, ctl}, {26'd0, C_NONE});
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("mat_no_restart", {26'd0, ctl}, {26'd0, C_NONE});
        end
`ifdef HAZARD_STATS_EN
        exp_stall = 32'd6;
        exp_ops   = 32'd1;
`else
        exp_stall = 32'd0;
        exp_ops   = 32'd0;
`endif
        chk("stat_stall", stat_stall_cycles, exp_stall);
        chk("stat_ops", stat_mat_ops, exp_ops);
        chk("stat_flush", stat_flushes, 32'd0);

        // Watchdog: eight WAIT cycles without done.
        tick(); id_mat_valid = 1'b1; #1;
        chk("wd_T", {26'd0, ctl}, {26'd0, C_STALL});
        tick(); id_mat_valid = 1'b0; #1;
        chk("wd_issue", {26'd0, ctl}, {26'd0, C_ISSUE});
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("wd_wait", {26'd0, ctl}, {26'd0, C_WAIT});
            chk("wd_err_low", {31'd0, mat_err}, 32'd0);
        end
        tick(); #1;
        chk("wd_done_ctl", {26'd0, ctl}, {26'd0, C_NONE});
        chk("wd_err_set", {31'd0, mat_err}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("wd_idle_ctl", {26'd0, ctl}, {26'd0, C_NONE});
            chk("wd_err_sticky", {31'd0, mat_err}, 32'd1);
        end
        do_reset();
        #1;
        chk("wd_err_cleared", {31'd0, mat_err}, 32'd0);

        // Done coincident with the timeout cycle: no error.
        tick(); id_mat_valid = 1'b1; #1;
        chk("tie_T", {26'd0, ctl}, {26'd0, C_STALL});
        tick(); id_mat_valid = 1'b0; #1;
        chk("tie_issue", {26'd0, ctl}, {26'd0, C_ISSUE});
        for (int i = 0; i < 7; i++) begin
            tick(); #1;
        end
        tick(); mat_done = 1'b1; #1;
        chk("tie_last_wait", {26'd0, ctl}, {26'd0, C_WAIT});
        tick(); mat_done = 1'b0; #1;
        chk("tie_done_ctl", {26'd0, ctl}, {26'd0, C_NONE});
        chk("tie_no_err", {31'd0, mat_err}, 32'd0);

        // Reset in the middle of WAIT, then a late done.
        tick(); id_mat_valid = 1'b1; #1;
        tick(); id_mat_valid = 1'b0; #1;
        chk("rw_issue", {26'd0, ctl}, {26'd0, C_ISSUE});
        repeat (2) begin
            tick(); #1;
        end
        chk("rw_wait", {26'd0, ctl}, {26'd0, C_WAIT});
        tick(); rst = 1'b0; #1;
        chk("rw_in_reset", {26'd0, ctl}, {26'd0, C_NONE});
        tick(); rst = 1'b1; mat_done = 1'b1; #1;
        chk("rw_late_done", {26'd0, ctl}, {26'd0, C_NONE});
        tick(); mat_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("rw_idle", {26'd0, ctl}, {26'd0, C_NONE});
        end
        chk("rw_err", {31'd0, mat_err}, 32'd0);
        chk("rw_stat_ops", stat_mat_ops, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage core. It generates the stall and flush controls for the IF/ID and ID/EX pipeline registers and the PC.
- Resolves three hazard sources: load-use, taken branch, multi-cycle matrix instruction.
- Sequences the external matrix unit: start pulse, wait for done, watchdog timeout.

Parameters:
MAT_TIMEOUT, 1024, max cycles in WAIT before forced abort; 0 disables the watchdog
CNT_W, 11, width of the watchdog counter; must hold MAT_TIMEOUT

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
id_rs1  input  5  rs1 index of the instruction in ID
id_rs2  input  5  rs2 index of the instruction in ID
id_rs1_used  input  1  instruction in ID reads rs1
id_rs2_used  input  1  instruction in ID reads rs2
id_mat_valid  input  1  instruction in ID is a matrix instruction
ex_rd  input  5  destination register of the instruction in EX
ex_mem_read  input  1  instruction in EX is a load
ex_branch_taken  input  1  branch/jump resolved taken in EX
mat_done  input  1  matrix unit completion pulse
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID
id_ex_flush  output  1  insert bubble into ID/EX
mat_start  output  1  one-cycle start pulse to the matrix unit
mat_busy  output  1  state is ISSUE or WAIT
mat_err  output  1  sticky, set on watchdog abort
stat_stall_cycles  output  32  cycles with pc_stall=1
stat_flushes  output  32  cycles with if_id_flush=1
stat_mat_ops  output  32  matrix ops started

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low. While rst=0:
  - state goes to IDLE, the counter clears, mat_err clears.
  - All outputs are 0.
  - Reset mid-operation aborts the matrix op; no mat_start is issued afterwards.
- FSM states: IDLE, ISSUE, WAIT, DONE. Control outputs are combinational from state and inputs in the same cycle; state, counter and mat_err are registered.
- Load-use term: lu = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- IDLE, evaluated in priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_flush=1, no stalls, stay IDLE. id_mat_valid and lu are ignored.
  2. lu: pc_stall=1, if_id_stall=1, id_ex_flush=1, stay IDLE.
  3. id_mat_valid: pc_stall=1, if_id_stall=1, id_ex_flush=1, go to ISSUE.
  4. Otherwise: all controls 0.
- ISSUE (exactly 1 cycle):
  - mat_start=1, mat_busy=1, pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Counter cleared; go to WAIT.
- WAIT:
  - mat_busy=1, stalls and id_ex_flush held.
  - Counter increments each cycle.
  - On mat_done, go to DONE.
  - If MAT_TIMEOUT!=0 and the counter reaches MAT_TIMEOUT-1 without mat_done: set mat_err, go to DONE.
  - mat_done and timeout in the same cycle: done wins, mat_err is not set.
- DONE (1 cycle):
  - All controls 0, so the matrix instruction advances to EX.
  - id_mat_valid is ignored, so the op does not retrigger.
  - Go to IDLE.
- Outside IDLE: ex_branch_taken and lu are ignored, since EX holds only bubbles. mat_done outside WAIT is ignored.
- Latency: ID detection to mat_start is 1 cycle; mat_done to pipeline release is 1 cycle (DONE).

Optional Feature:
HAZARD_STATS_EN
- Defined: three 32-bit saturating counters, cleared by reset, drive the stat_* ports.
  - stat_stall_cycles increments on each pc_stall=1 cycle.
  - stat_flushes increments on each if_id_flush=1 cycle.
  - stat_mat_ops increments on each mat_start=1 cycle.
  - Counters hold at 0xFFFFFFFF.
- Undefined: stat_* ports tied to 0 and no counter flops are synthesized.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_stall=if_id_stall=id_ex_flush=1 same cycle; ex_rd=0 with id_rs1=0 -> no stall.
2. Matrix op: id_mat_valid=1 at T -> stalls at T, mat_start=1 only at T+1, mat_busy T+1..; mat_done at T+5 -> DONE at T+6 with all controls 0, IDLE at T+7, no second mat_start.
3. Branch vs matrix: ex_branch_taken=1 and id_mat_valid=1 same cycle -> if_id_flush=id_ex_flush=1, mat_start never asserted, state stays IDLE.
4. Watchdog: MAT_TIMEOUT=8, no mat_done -> mat_err=1 after 8 WAIT cycles, then DONE, then IDLE; mat_err stays 1 until rst=0.
5. Reset during WAIT: rst=0 for 1 cycle -> next cycle all outputs 0, IDLE; a late mat_done is ignored.
6. HAZARD_STATS_EN: run test 2 -> stat_mat_ops=1, stat_stall_cycles=6 (T, ISSUE, four WAIT cycles); without the macro all stat_* read 0.
